// File: rtl/multi_cycle_controller.sv
// Multi-cycle control sequencer for the 16-bit CPU datapath.
// Moore state decode with a memory wait-state handshake, an illegal-opcode trap and a retire counter.
module multi_cycle_controller (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  opcode,
    input  logic [3:0]  Funct_field,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        PC_Write,
    output logic        IR_Write,
    output logic        Reg_Write,
    output logic        Mem_Read,
    output logic        Mem_Write,
    output logic        IorD,
    output logic        Mem_to_Reg,
    output logic        Reg_Dst,
    output logic        ALU_Src_A,
    output logic [1:0]  ALU_Src_B,
    output logic [3:0]  ALU_op,
    output logic [1:0]  PC_Src,
    output logic [3:0]  state,
    output logic        illegal_op,
    output logic [15:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_TRAP      = 4'd11
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic        retire_s;
    logic        illegal_op_r;
    logic [15:0] instr_count_r;

    logic        pc_write_s, ir_write_s, reg_write_s, mem_read_s, mem_write_s;
    logic        iord_s, mem_to_reg_s, reg_dst_s, alu_src_a_s;
    logic [1:0]  alu_src_b_s, pc_src_s;
    logic [3:0]  alu_op_s;

    function automatic logic [3:0] funct_to_alu_op(input logic [3:0] funct);
        case (funct)
            4'd0:    funct_to_alu_op = 4'b0000;
            4'd1:    funct_to_alu_op = 4'b0001;
            4'd2:    funct_to_alu_op = 4'b0010;
            4'd3:    funct_to_alu_op = 4'b0011;
            default: funct_to_alu_op = 4'b0000;
        endcase
    endfunction

    // Next-state selection and retire detection
    always_comb begin
        next_state_s = S_TRAP;
        retire_s     = 1'b0;
        case (state_r)
            S_FETCH:     next_state_s = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    4'd0:       next_state_s = S_EXEC_R;
                    4'd1, 4'd2: next_state_s = S_MEM_ADDR;
                    4'd3:       next_state_s = S_EXEC_I;
                    4'd4, 4'd5: next_state_s = S_BRANCH;
                    4'd6:       next_state_s = S_JUMP;
                    default:    next_state_s = S_TRAP;
                endcase
            end
            S_MEM_ADDR: begin
                if (opcode == 4'd1) begin
                    next_state_s = S_MEM_READ;
                end else if (opcode == 4'd2) begin
                    next_state_s = S_MEM_WRITE;
                end else begin
                    next_state_s = S_TRAP;
                end
            end
            S_MEM_READ:  next_state_s = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB: begin
                next_state_s = S_FETCH;
                retire_s     = 1'b1;
            end
            S_MEM_WRITE: begin
                next_state_s = mem_ready ? S_FETCH : S_MEM_WRITE;
                retire_s     = mem_ready;
            end
            S_EXEC_R:    next_state_s = S_ALU_WB;
            S_EXEC_I:    next_state_s = S_ALU_WB;
            S_ALU_WB, S_BRANCH, S_JUMP: begin
                next_state_s = S_FETCH;
                retire_s     = 1'b1;
            end
            S_TRAP:      next_state_s = S_TRAP;
            default:     next_state_s = S_TRAP;
        endcase
    end

    // Control decode of the current state
    always_comb begin
        pc_write_s   = 1'b0;
        ir_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        iord_s       = 1'b0;
        mem_to_reg_s = 1'b0;
        reg_dst_s    = 1'b0;
        alu_src_a_s  = 1'b0;
        alu_src_b_s  = 2'b00;
        alu_op_s     = 4'b0000;
        pc_src_s     = 2'b00;
        case (state_r)
            S_FETCH: begin
                mem_read_s  = 1'b1;
                alu_src_b_s = 2'b01;
                ir_write_s  = mem_ready;
                pc_write_s  = mem_ready;
            end
            S_DECODE:    alu_src_b_s = 2'b10;
            S_MEM_ADDR, S_EXEC_I: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
            end
            S_MEM_READ: begin
                mem_read_s = 1'b1;
                iord_s     = 1'b1;
            end
            S_MEM_WB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write_s = 1'b1;
                iord_s      = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a_s = 1'b1;
                alu_op_s    = funct_to_alu_op(Funct_field);
            end
            S_ALU_WB: begin
                reg_write_s = 1'b1;
                reg_dst_s   = (opcode == 4'd0);
            end
            S_BRANCH: begin
                alu_src_a_s = 1'b1;
                alu_op_s    = 4'b0001;
                pc_src_s    = 2'b01;
                if (opcode == 4'd4) begin
                    pc_write_s = zero;
                end else if (opcode == 4'd5) begin
                    pc_write_s = ~zero;
                end else begin
                    pc_write_s = 1'b0;
                end
            end
            S_JUMP: begin
                pc_write_s = 1'b1;
                pc_src_s   = 2'b10;
            end
            default: pc_write_s = 1'b0;
        endcase
    end

    // State, sticky trap flag and retired-instruction counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= S_FETCH;
            illegal_op_r  <= 1'b0;
            instr_count_r <= 16'd0;
        end else begin
            state_r <= next_state_s;
            if (next_state_s == S_TRAP) begin
                illegal_op_r <= 1'b1;
            end
            if (retire_s) begin
                instr_count_r <= instr_count_r + 16'd1;
            end
        end
    end

    // Reset gates every control line so an aborted instruction cannot write
    assign PC_Write    = rst_n & pc_write_s;
    assign IR_Write    = rst_n & ir_write_s;
    assign Reg_Write   = rst_n & reg_write_s;
    assign Mem_Read    = rst_n & mem_read_s;
    assign Mem_Write   = rst_n & mem_write_s;
    assign IorD        = rst_n & iord_s;
    assign Mem_to_Reg  = rst_n & mem_to_reg_s;
    assign Reg_Dst     = rst_n & reg_dst_s;
    assign ALU_Src_A   = rst_n & alu_src_a_s;
    assign ALU_Src_B   = rst_n ? alu_src_b_s : 2'b00;
    assign ALU_op      = rst_n ? alu_op_s    : 4'b0000;
    assign PC_Src      = rst_n ? pc_src_s    : 2'b00;
    assign state       = state_r;
    assign illegal_op  = illegal_op_r;
    assign instr_count = instr_count_r;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Scoreboard bench for multi_cycle_controller: per-cycle expectations queued by the driver,
// popped and compared by a negedge monitor.
module tb_multi_cycle_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  opcode = 4'd0;
    logic [3:0]  funct_field = 4'd0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        PC_Write, IR_Write, Reg_Write, Mem_Read, Mem_Write;
    logic        IorD, Mem_to_Reg, Reg_Dst, ALU_Src_A, illegal_op;
    logic [1:0]  ALU_Src_B, PC_Src;
    logic [3:0]  ALU_op, state;
    logic [15:0] instr_count;
    logic [16:0] ctl;

    multi_cycle_controller dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .Funct_field(funct_field),
        .zero(zero), .mem_ready(mem_ready),
        .PC_Write(PC_Write), .IR_Write(IR_Write), .Reg_Write(Reg_Write),
        .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .IorD(IorD),
        .Mem_to_Reg(Mem_to_Reg), .Reg_Dst(Reg_Dst), .ALU_Src_A(ALU_Src_A),
        .ALU_Src_B(ALU_Src_B), .ALU_op(ALU_op), .PC_Src(PC_Src),
        .state(state), .illegal_op(illegal_op), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // {PC_Write, IR_Write, Reg_Write, Mem_Read, Mem_Write, IorD, Mem_to_Reg, Reg_Dst, ALU_Src_A, ALU_Src_B, ALU_op, PC_Src}
    assign ctl = {PC_Write, IR_Write, Reg_Write, Mem_Read, Mem_Write, IorD,
                  Mem_to_Reg, Reg_Dst, ALU_Src_A, ALU_Src_B, ALU_op, PC_Src};

    localparam logic [16:0] C_ZERO     = 17'b0_0_0_0_0_0_0_0_0_00_0000_00;
    localparam logic [16:0] C_FETCH_GO = 17'b1_1_0_1_0_0_0_0_0_01_0000_00;
    localparam logic [16:0] C_FETCH_WT = 17'b0_0_0_1_0_0_0_0_0_01_0000_00;
    localparam logic [16:0] C_DECODE   = 17'b0_0_0_0_0_0_0_0_0_10_0000_00;
    localparam logic [16:0] C_MEM_ADDR = 17'b0_0_0_0_0_0_0_0_1_10_0000_00;
    localparam logic [16:0] C_MEM_READ = 17'b0_0_0_1_0_1_0_0_0_00_0000_00;
    localparam logic [16:0] C_MEM_WB   = 17'b0_0_1_0_0_0_1_0_0_00_0000_00;
    localparam logic [16:0] C_MEM_WR   = 17'b0_0_0_0_1_1_0_0_0_00_0000_00;
    localparam logic [16:0] C_EXEC_R0  = 17'b0_0_0_0_0_0_0_0_1_00_0000_00;
    localparam logic [16:0] C_EXEC_I   = 17'b0_0_0_0_0_0_0_0_1_10_0000_00;
    localparam logic [16:0] C_WB_R     = 17'b0_0_1_0_0_0_0_1_0_00_0000_00;
    localparam logic [16:0] C_WB_I     = 17'b0_0_1_0_0_0_0_0_0_00_0000_00;
    localparam logic [16:0] C_BR_NT    = 17'b0_0_0_0_0_0_0_0_1_00_0001_01;
    localparam logic [16:0] C_BR_T     = 17'b1_0_0_0_0_0_0_0_1_00_0001_01;
    localparam logic [16:0] C_JUMP     = 17'b1_0_0_0_0_0_0_0_0_00_0000_10;

    logic [37:0] exp_q[$];
    string       nm_q[$];
    logic [15:0] cnt = 16'd0;
    int          n_checks = 0;
    int          n_fail = 0;

    // Monitor: compare every queued expectation against the DUT outputs mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [37:0] e;
            string       nm;
            e  = exp_q.pop_front();
            nm = nm_q.pop_front();
            n_checks = n_checks + 4;
            if (state !== e[37:34]) begin
                n_fail++;
                $display("FAIL %s state: got %0d expected %0d", nm, state, e[37:34]);
            end
            if (ctl !== e[33:17]) begin
                n_fail++;
                $display("FAIL %s controls: got %b expected %b", nm, ctl, e[33:17]);
            end
            if (instr_count !== e[16:1]) begin
                n_fail++;
                $display("FAIL %s instr_count: got %h expected %h", nm, instr_count, e[16:1]);
            end
            if (illegal_op !== e[0]) begin
                n_fail++;
                $display("FAIL %s illegal_op: got %b expected %b", nm, illegal_op, e[0]);
            end
        end
    end

    task automatic step(input logic rn, input logic [3:0] op, input logic [3:0] fn,
                        input logic z, input logic mr, input logic [3:0] es,
                        input logic [16:0] ec, input logic eill, input string nm);
        rst_n = rn; opcode = op; funct_field = fn; zero = z; mem_ready = mr;
        exp_q.push_back({es, ec, cnt, eill});
        nm_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic r_type(input logic [3:0] fn, input logic [3:0] aop);
        step(1'b1, 4'd0, fn, 1'b0, 1'b1, 4'd0, C_FETCH_GO, 1'b0, "rt_fetch");
        step(1'b1, 4'd0, fn, 1'b0, 1'b1, 4'd1, C_DECODE, 1'b0, "rt_decode");
        step(1'b1, 4'd0, fn, 1'b0, 1'b1, 4'd6, C_EXEC_R0 | {11'd0, aop, 2'b00}, 1'b0, "rt_exec");
        step(1'b1, 4'd0, fn, 1'b0, 1'b1, 4'd8, C_WB_R, 1'b0, "rt_wb");
        cnt = cnt + 16'd1;
    endtask

    task automatic branch(input logic [3:0] op, input logic z, input logic [16:0] ebr);
        step(1'b1, op, 4'd0, z, 1'b1, 4'd0, C_FETCH_GO, 1'b0, "br_fetch");
        step(1'b1, op, 4'd0, z, 1'b1, 4'd1, C_DECODE, 1'b0, "br_decode");
        step(1'b1, op, 4'd0, z, 1'b1, 4'd9, ebr, 1'b0, "br_exec");
        cnt = cnt + 16'd1;
    endtask

    task automatic jump();
        step(1'b1, 4'd6, 4'd0, 1'b0, 1'b1, 4'd0, C_FETCH_GO, 1'b0, "j_fetch");
        step(1'b1, 4'd6, 4'd0, 1'b0, 1'b1, 4'd1, C_DECODE, 1'b0, "j_decode");
        step(1'b1, 4'd6, 4'd0, 1'b0, 1'b0, 4'd10, C_JUMP, 1'b0, "j_exec");
        cnt = cnt + 16'd1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        step(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 4'd0, C_ZERO, 1'b0, "reset0");
        step(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 4'd0, C_ZERO, 1'b0, "reset1");

        r_type(4'd1, 4'b0001);
        r_type(4'd2, 4'b0010);
        r_type(4'd3, 4'b0011);
        r_type(4'd10, 4'b0000);

        // addi
        step(1'b1, 4'd3, 4'd0, 1'b0, 1'b1, 4'd0, C_FETCH_GO, 1'b0, "addi_fetch");
        step(1'b1, 4'd3, 4'd0, 1'b0, 1'b1, 4'd1, C_DECODE, 1'b0, "addi_decode");
        step(1'b1, 4'd3, 4'd0, 1'b0, 1'b1, 4'd7, C_EXEC_I, 1'b0, "addi_exec");
        step(1'b1, 4'd3, 4'd0, 1'b0, 1'b1, 4'd8, C_WB_I, 1'b0, "addi_wb");
        cnt = cnt + 16'd1;

        // LW with two wait cycles in MEM_READ: 7 cycles
        step(1'b1, 4'd1, 4'd0, 1'b0, 1'b1, 4'd0, C_FETCH_GO, 1'b0, "lw_fetch");
        step(1'b1, 4'd1, 4'd0, 1'b0, 1'b0, 4'd1, C_DECODE, 1'b0, "lw_decode");
        step(1'b1, 4'd1, 4'd0, 1'b0, 1'b0, 4'd2, C_MEM_ADDR, 1'b0, "lw_addr");
        step(1'b1, 4'd1, 4'd0, 1'b0, 1'b0, 4'd3, C_MEM_READ, 1'b0, "lw_read_w0");
        step(1'b1, 4'd1, 4'd0, 1'b0, 1'b0, 4'd3, C_MEM_READ, 1'b0, "lw_read_w1");
        step(1'b1, 4'd1, 4'd0, 1'b0, 1'b1, 4'd3, C_MEM_READ, 1'b0, "lw_read_go");
        step(1'b1, 4'd1, 4'd0, 1'b0, 1'b0, 4'd4, C_MEM_WB, 1'b0, "lw_wb");
        cnt = cnt + 16'd1;

        // SW with one fetch wait and one store wait
        step(1'b1, 4'd2, 4'd0, 1'b0, 1'b0, 4'd0, C_FETCH_WT, 1'b0, "sw_fetch_wt");
        step(1'b1, 4'd2, 4'd0, 1'b0, 1'b1, 4'd0, C_FETCH_GO, 1'b0, "sw_fetch");
        step(1'b1, 4'd2, 4'd0, 1'b0, 1'b1, 4'd1, C_DECODE, 1'b0, "sw_decode");
        step(1'b1, 4'd2, 4'd0, 1'b0, 1'b1, 4'd2, C_MEM_ADDR, 1'b0, "sw_addr");
        step(1'b1, 4'd2, 4'd0, 1'b0, 1'b0, 4'd5, C_MEM_WR, 1'b0, "sw_write_wt");
        step(1'b1, 4'd2, 4'd0, 1'b0, 1'b1, 4'd5, C_MEM_WR, 1'b0, "sw_write_go");
        cnt = cnt + 16'd1;

        branch(4'd4, 1'b1, C_BR_T);
        branch(4'd4, 1'b0, C_BR_NT);
        branch(4'd5, 1'b1, C_BR_NT);
        branch(4'd5, 1'b0, C_BR_T);
        jump();

        // Reset pulse in the middle of a stalled store
        step(1'b1, 4'd2, 4'd0, 1'b0, 1'b1, 4'd0, C_FETCH_GO, 1'b0, "rs_fetch");
        step(1'b1, 4'd2, 4'd0, 1'b0, 1'b1, 4'd1, C_DECODE, 1'b0, "rs_decode");
        step(1'b1, 4'd2, 4'd0, 1'b0, 1'b1, 4'd2, C_MEM_ADDR, 1'b0, "rs_addr");
        step(1'b1, 4'd2, 4'd0, 1'b0, 1'b0, 4'd5, C_MEM_WR, 1'b0, "rs_write_wt");
        cnt = 16'd0;
        step(1'b0, 4'd2, 4'd0, 1'b0, 1'b0, 4'd0, C_ZERO, 1'b0, "rs_in_reset");
        jump();

        // Counter wrap: preload near the top, then two jumps
        force dut.instr_count_r = 16'hFFFE;
        #1;
        release dut.instr_count_r;
        cnt = 16'hFFFE;
        jump();
        jump();
        step(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, C_FETCH_WT, 1'b0, "wrap_after");

        // Illegal opcode: terminal trap
        step(1'b1, 4'd9, 4'd0, 1'b1, 1'b1, 4'd0, C_FETCH_GO, 1'b0, "ill_fetch");
        step(1'b1, 4'd9, 4'd0, 1'b1, 1'b1, 4'd1, C_DECODE, 1'b0, "ill_decode");
        for (int i = 0; i < 11; i++) begin
            step(1'b1, 4'd9, 4'd0, 1'b1, 1'b1, 4'd11, C_ZERO, 1'b1, "ill_trap");
        end

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_cycle_controller.md
# multi_cycle_controller

Multi-cycle sequencer for the 16-bit CPU datapath. It replaces the single-cycle control decode with a registered state machine, so one ALU and one unified instruction/data memory port are shared across the phases of each instruction. It decodes the same ISA: R-type, LW, SW, addi, beq, bne and jump. It also adds a memory wait-state handshake, an illegal-opcode trap and a retired-instruction counter. The block sits between the instruction register (IR) and the datapath muxes and enables.

## Interface
- No parameters. The state encoding is fixed below.
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  4  IR[15:12], stable from the cycle after the IR write
- Funct_field  in  4  IR[3:0], R-type function
- zero  in  1  ALU zero flag; valid in the BRANCH state
- mem_ready  in  1  memory has completed the current read or write this cycle
- PC_Write, IR_Write, Reg_Write, Mem_Read, Mem_Write  out  1  enables
- IorD  out  1  memory address source: 0 = PC, 1 = ALUOut
- Mem_to_Reg, Reg_Dst  out  1  writeback data source / destination field select
- ALU_Src_A  out  1  0 = PC, 1 = register A
- ALU_Src_B  out  2  00 = register B, 01 = constant 1, 10 = sign-extended immediate
- ALU_op  out  4  0000 add, 0001 sub, 0010 sll, 0011 and
- PC_Src  out  2  00 = ALU result, 01 = ALUOut (branch target), 10 = jump target
- state  out  4  current state, for debug
- illegal_op  out  1  sticky trap flag
- instr_count  out  16  count of retired instructions

## Operation
- **Unlisted-output rule:** every output not listed for a state is 0.
- **FETCH (0)**
  - Outputs: Mem_Read=1, IorD=0, ALU_Src_A=0, ALU_Src_B=01, ALU_op=add, PC_Src=00.
  - IR_Write and PC_Write equal mem_ready.
  - Next state: DECODE if mem_ready, else stay in FETCH.
- **DECODE (1)**
  - Outputs: ALU_Src_A=0, ALU_Src_B=10, ALU_op=add. This precomputes the branch target into ALUOut.
  - Next state by opcode: 0→EXEC_R; 1,2→MEM_ADDR; 3→EXEC_I; 4,5→BRANCH; 6→JUMP; 7–15→TRAP.
- **MEM_ADDR (2)**
  - Outputs: ALU_Src_A=1, ALU_Src_B=10, add.
  - Next state: MEM_READ for opcode 1, MEM_WRITE for opcode 2.
- **MEM_READ (3)**
  - Outputs: Mem_Read=1, IorD=1.
  - Next state: MEM_WB when mem_ready, else hold.
- **MEM_WB (4)**
  - Outputs: Reg_Write=1, Mem_to_Reg=1, Reg_Dst=0.
  - Next state: FETCH; the instruction retires.
- **MEM_WRITE (5)**
  - Outputs: Mem_Write=1, IorD=1.
  - Next state: FETCH when mem_ready, and the instruction retires; else hold.
- **EXEC_R (6)**
  - Outputs: ALU_Src_A=1, ALU_Src_B=00.
  - ALU_op from Funct_field: 0→0000, 1→0001, 2→0010, 3→0011, otherwise 0000.
  - Next state: ALU_WB.
- **EXEC_I (7)**
  - Outputs: ALU_Src_A=1, ALU_Src_B=10, add.
  - Next state: ALU_WB.
- **ALU_WB (8)**
  - Outputs: Reg_Write=1, Mem_to_Reg=0, Reg_Dst=1 if opcode=0, else 0.
  - Next state: FETCH; the instruction retires.
- **BRANCH (9)**
  - Outputs: ALU_Src_A=1, ALU_Src_B=00, sub, PC_Src=01.
  - PC_Write = zero for opcode 4, and = ~zero for opcode 5.
  - Next state: FETCH; the instruction retires whether or not the branch is taken.
- **JUMP (10)**
  - Outputs: PC_Write=1, PC_Src=10.
  - Next state: FETCH; the instruction retires.
- **TRAP (11)**
  - All enables 0; illegal_op set to 1. The state is terminal; only reset leaves it.
  - The trapping instruction does not retire.
- **Encodings 12–15:** unreachable; if entered, go to TRAP next cycle.
- **Memory handshake:** the request (Mem_Read or Mem_Write) and IorD are held constant until a rising edge with mem_ready=1. mem_ready is ignored in all non-memory states.
- **Retire counter:** instr_count increments by 1 on each retiring transition and wraps from 0xFFFF to 0x0000.

## Timing
- **Reset values:** while rst_n=0, state=FETCH, illegal_op=0, instr_count=0, and all enables (PC_Write, IR_Write, Reg_Write, Mem_Read, Mem_Write) are forced to 0 combinationally. The mux selects are 0.
- **Reset release:** the first FETCH request appears in the cycle after rst_n deasserts.
- **Reset mid-instruction:** reset asserted mid-instruction aborts it immediately; there is no partial write after assertion.
- **Output timing:** outputs are a Moore decode of state, plus three combinational input dependencies: mem_ready for the FETCH enables, zero for the BRANCH PC_Write, and Funct_field/opcode for ALU_op and Reg_Dst.
- **Cycles per instruction with mem_ready tied to 1:**
  - R-type and addi: 4
  - LW: 5
  - SW: 4
  - beq, bne and jump: 3
  - Each cycle of mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds 1 cycle.

## Test plan
- **Reset then R-type:** reset, then an R-type instruction with Funct_field=0001 and mem_ready=1. Required: states 0→1→6→8→0; ALU_op=0001 in EXEC_R; Reg_Write=1 and Reg_Dst=1 in ALU_WB; instr_count=1.
- **LW with wait states:** LW with mem_ready low for 2 cycles in MEM_READ. Required: MEM_READ held for 3 cycles with Mem_Read=1 and IorD=1 constant; 7 cycles total; Reg_Write and Mem_to_Reg both 1 in MEM_WB.
- **Branches:** beq with zero=1 gives PC_Write=1 and PC_Src=01 in BRANCH. bne with zero=1 gives PC_Write=0. Both take 3 cycles and increment instr_count.
- **Illegal opcode:** opcode 1001. Required: TRAP on the cycle after DECODE; illegal_op=1; all enables 0 for 10+ cycles; instr_count unchanged.
- **Reset mid-store:** rst_n pulsed low during MEM_WRITE while mem_ready=0. Required: Mem_Write drops in the same cycle; state=0 and instr_count=0; normal fetch resumes after release.
- **Counter wrap:** preload via 65,535 jumps, then one more jump. Required: instr_count goes 0xFFFF→0x0000.
